// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding, sizes.
package irq_ctrl_pkg;

    localparam int unsigned IdW = 5;

    localparam logic [2:0] RegPend   = 3'd0;
    localparam logic [2:0] RegEna    = 3'd1;
    localparam logic [2:0] RegActive = 3'd2;
    localparam logic [2:0] RegVec    = 3'd3;
    localparam logic [2:0] RegCtrl   = 3'd4;
    localparam logic [2:0] RegSwset  = 3'd5;
    localparam logic [2:0] RegEoi    = 3'd6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StSvc  = 2'd2
    } state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// Bus slave window plus the CPU request/ack handshake of the interrupt controller.
interface irq_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    import irq_ctrl_pkg::*;

    logic             cs;
    logic             wen;
    logic [2:0]       addr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             irq_req;
    logic [IdW-1:0]   irq_id;
    logic             irq_ack;
    logic             in_service;

    modport master (
        output cs, wen, addr, din, irq_ack,
        input  dout, irq_req, irq_id, in_service
    );

    modport slave (
        input  cs, wen, addr, din, irq_ack,
        output dout, irq_req, irq_id, in_service
    );

endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder: idx_o is the lowest set bit of vec_i.
module irq_ctrl_prio_enc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDW   = 5
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDW-1:0]   idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o = '0;
        // Scan downwards so the last hit, the lowest index, wins.
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDW'(i);
            end
        end
        valid_o = |vec_i;
    end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: edge-latched pending bits, enable mask,
// fixed lowest-index priority and a request/ack/EOI handshake towards the CPU.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] irq_in,
    irq_ctrl_if.slave        bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] ena_q, ena_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             gen_q, gen_d;
    logic             irq_req_q, irq_req_d;
    logic             in_service_q, in_service_d;
    logic [IdW-1:0]   irq_id_q, irq_id_d;

    logic             wr;
    logic             eoi_wr;
    logic             ack_fire;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] sws;
    logic [WIDTH-1:0] ack_clr;
    logic [IdW-1:0]   enc_idx;
    logic             enc_valid;

    assign active = pend_q & ena_q;

    irq_ctrl_prio_enc #(
        .WIDTH (WIDTH),
        .IDW   (IdW)
    ) u_prio_enc (
        .vec_i   (active),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    always_comb begin
        wr      = bus.cs & bus.wen;
        eoi_wr  = wr && (bus.addr == RegEoi);
        prev_d  = irq_in;
        rise    = irq_in & ~prev_q;
        ena_d   = (wr && (bus.addr == RegEna)) ? bus.din : ena_q;
        gen_d   = (wr && (bus.addr == RegCtrl)) ? bus.din[0] : gen_q;
        w1c     = (wr && (bus.addr == RegPend)) ? bus.din : '0;
        sws     = (wr && (bus.addr == RegSwset)) ? bus.din : '0;
        ack_clr = ack_fire ? (WIDTH'(1) << irq_id_q) : '0;
        // Sets are applied after clears so a simultaneous set always wins.
        pend_d  = (pend_q & ~(w1c | ack_clr)) | rise | sws;
    end

    always_comb begin
        state_d      = state_q;
        irq_req_d    = irq_req_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;
        ack_fire     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gen_q && enc_valid) begin
                    state_d   = StReq;
                    irq_req_d = 1'b1;
                    irq_id_d  = enc_idx;
                end
            end
            StReq: begin
                // irq_id stays frozen; only withdrawal or ack leaves this state.
                if (!gen_q || !active[irq_id_q]) begin
                    state_d   = StIdle;
                    irq_req_d = 1'b0;
                end else if (bus.irq_ack) begin
                    ack_fire     = 1'b1;
                    irq_req_d    = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = StSvc;
                end
            end
            StSvc: begin
                if (eoi_wr) begin
                    in_service_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d   = StIdle;
                irq_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.dout = '0;
        if (bus.cs) begin
            case (bus.addr)
                RegPend:   bus.dout = pend_q;
                RegEna:    bus.dout = ena_q;
                RegActive: bus.dout = active;
                RegVec:    bus.dout = {in_service_q, {(WIDTH - IdW - 1){1'b0}}, irq_id_q};
                RegCtrl:   bus.dout = {{(WIDTH - 1){1'b0}}, gen_q};
                default:   bus.dout = '0;
            endcase
        end
    end

    assign bus.irq_req    = irq_req_q;
    assign bus.irq_id     = irq_id_q;
    assign bus.in_service = in_service_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            pend_q       <= '0;
            ena_q        <= '0;
            prev_q       <= '0;
            gen_q        <= 1'b0;
            irq_req_q    <= 1'b0;
            in_service_q <= 1'b0;
            irq_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            ena_q        <= ena_d;
            prev_q       <= prev_d;
            gen_q        <= gen_d;
            irq_req_q    <= irq_req_d;
            in_service_q <= in_service_d;
            irq_id_q     <= irq_id_d;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expectations are queued alongside stimulus and
// drained against DUT outputs on the falling clock edge.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam int KDout = 0;
    localparam int KReq  = 1;
    localparam int KId   = 2;
    localparam int KSvc  = 3;

    typedef struct {
        string       tag;
        int          kind;
        logic [2:0]  addr;
        logic [31:0] exp;
    } exp_t;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic [31:0] irq_in = '0;
    exp_t        sb_q[$];
    int          total  = 0;
    int          bad    = 0;

    irq_ctrl_if bus_if ();

    irq_ctrl u_dut (
        .clk    (clk),
        .reset  (reset),
        .irq_in (irq_in),
        .bus    (bus_if)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void expect_out(input string tag, input int kind, input logic [2:0] a,
                                       input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.addr = a;
        e.exp  = exp;
        sb_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_if.cs   = 1'b1;
        bus_if.wen  = 1'b1;
        bus_if.addr = a;
        bus_if.din  = d;
        tick();
        bus_if.cs   = 1'b0;
        bus_if.wen  = 1'b0;
    endtask

    task automatic ack();
        bus_if.irq_ack = 1'b1;
        tick();
        bus_if.irq_ack = 1'b0;
    endtask

    // Half period is 10 units, so up to nine register reads fit before the next edge.
    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                KDout: begin
                    bus_if.cs   = 1'b1;
                    bus_if.wen  = 1'b0;
                    bus_if.addr = e.addr;
                    #1;
                    obs = bus_if.dout;
                    bus_if.cs = 1'b0;
                end
                KReq:    obs = {31'd0, bus_if.irq_req};
                KId:     obs = {27'd0, bus_if.irq_id};
                default: obs = {31'd0, bus_if.in_service};
            endcase
            check(e.tag, obs, e.exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.cs      = 1'b0;
        bus_if.wen     = 1'b0;
        bus_if.addr    = '0;
        bus_if.din     = '0;
        bus_if.irq_ack = 1'b0;

        // Reset
        tick();
        tick();
        reset = 1'b1;
        expect_out("rst_pend", KDout, RegPend, 32'h0);
        expect_out("rst_ena", KDout, RegEna, 32'h0);
        expect_out("rst_ctrl", KDout, RegCtrl, 32'h0);
        expect_out("rst_vec", KDout, RegVec, 32'h0);
        expect_out("rst_req", KReq, 3'd0, 32'h0);
        expect_out("rst_svc", KSvc, 3'd0, 32'h0);
        drain();

        // Basic: edge -> PEND next cycle -> request the cycle after
        wr(RegEna, 32'h1);
        wr(RegCtrl, 32'h1);
        irq_in = 32'h1;
        tick();
        expect_out("basic_req_lat1", KReq, 3'd0, 32'h0);
        expect_out("basic_pend", KDout, RegPend, 32'h1);
        drain();
        tick();
        expect_out("basic_req", KReq, 3'd0, 32'h1);
        expect_out("basic_id", KId, 3'd0, 32'h0);
        drain();
        irq_in = 32'h0;
        ack();
        expect_out("basic_ack_pend", KDout, RegPend, 32'h0);
        expect_out("basic_ack_svc", KSvc, 3'd0, 32'h1);
        expect_out("basic_ack_req", KReq, 3'd0, 32'h0);
        expect_out("basic_vec", KDout, RegVec, 32'h8000_0000);
        drain();
        wr(RegEoi, 32'h0);
        expect_out("basic_eoi_svc", KSvc, 3'd0, 32'h0);
        expect_out("basic_eoi_vec", KDout, RegVec, 32'h0);
        drain();

        // Priority: bits 5 and 2 together, 2 served first
        wr(RegEna, 32'hFF);
        irq_in = 32'h24;
        tick();
        tick();
        expect_out("prio_req", KReq, 3'd0, 32'h1);
        expect_out("prio_id2", KId, 3'd0, 32'd2);
        expect_out("prio_active", KDout, RegActive, 32'h24);
        drain();
        irq_in = 32'h0;
        ack();
        expect_out("prio_pend_left", KDout, RegPend, 32'h20);
        expect_out("prio_svc", KSvc, 3'd0, 32'h1);
        expect_out("prio_no_req_svc", KReq, 3'd0, 32'h0);
        drain();
        wr(RegEoi, 32'h0);
        expect_out("prio_eoi_req", KReq, 3'd0, 32'h0);
        expect_out("prio_eoi_svc", KSvc, 3'd0, 32'h0);
        drain();
        tick();
        expect_out("prio_req5", KReq, 3'd0, 32'h1);
        expect_out("prio_id5", KId, 3'd0, 32'd5);
        drain();
        ack();
        wr(RegEoi, 32'h0);

        // Races: edge vs W1C on the same bit, level-held input
        wr(RegCtrl, 32'h0);
        wr(RegSwset, 32'h4);
        expect_out("swset", KDout, RegPend, 32'h4);
        drain();
        wr(RegPend, 32'h4);
        expect_out("w1c", KDout, RegPend, 32'h0);
        drain();
        irq_in = 32'h4;
        wr(RegPend, 32'h4);
        expect_out("race_set_wins", KDout, RegPend, 32'h4);
        drain();
        wr(RegPend, 32'h4);
        expect_out("held_no_reset", KDout, RegPend, 32'h0);
        drain();
        irq_in = 32'hC;
        tick();
        expect_out("level_edge", KDout, RegPend, 32'h8);
        drain();
        wr(RegPend, 32'h8);
        tick();
        tick();
        expect_out("level_once", KDout, RegPend, 32'h0);
        drain();
        irq_in = 32'h0;

        // Withdraw via W1C before ack
        wr(RegCtrl, 32'h1);
        wr(RegSwset, 32'h2);
        tick();
        expect_out("wd_req", KReq, 3'd0, 32'h1);
        expect_out("wd_id", KId, 3'd0, 32'd1);
        drain();
        wr(RegPend, 32'h2);
        expect_out("wd_hold", KReq, 3'd0, 32'h1);
        drain();
        tick();
        expect_out("wd_drop", KReq, 3'd0, 32'h0);
        expect_out("wd_vec", KDout, RegVec, 32'h1);
        drain();
        tick();
        expect_out("wd_idle", KReq, 3'd0, 32'h0);
        drain();

        // Pending while disabled, late enable, GEN withdraw
        wr(RegEna, 32'h0);
        wr(RegSwset, 32'h10);
        tick();
        expect_out("dis_req", KReq, 3'd0, 32'h0);
        expect_out("dis_pend", KDout, RegPend, 32'h10);
        expect_out("dis_active", KDout, RegActive, 32'h0);
        drain();
        wr(RegEna, 32'h10);
        expect_out("ena_lat", KReq, 3'd0, 32'h0);
        drain();
        tick();
        expect_out("ena_req", KReq, 3'd0, 32'h1);
        expect_out("ena_id", KId, 3'd0, 32'd4);
        drain();
        wr(RegCtrl, 32'h0);
        tick();
        expect_out("gen_withdraw", KReq, 3'd0, 32'h0);
        expect_out("gen_keep_pend", KDout, RegPend, 32'h10);
        drain();
        wr(RegPend, 32'h10);

        // Reset in the middle of service
        wr(RegEna, 32'hFF);
        wr(RegCtrl, 32'h1);
        wr(RegSwset, 32'h1);
        tick();
        ack();
        wr(RegSwset, 32'h8);
        expect_out("msvc_svc", KSvc, 3'd0, 32'h1);
        expect_out("msvc_pend", KDout, RegPend, 32'h8);
        expect_out("msvc_req", KReq, 3'd0, 32'h0);
        drain();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        expect_out("mrst_svc", KSvc, 3'd0, 32'h0);
        expect_out("mrst_pend", KDout, RegPend, 32'h0);
        expect_out("mrst_req", KReq, 3'd0, 32'h0);
        expect_out("mrst_ena", KDout, RegEna, 32'h0);
        expect_out("mrst_ctrl", KDout, RegCtrl, 32'h0);
        drain();
        ack();
        wr(RegEoi, 32'h0);
        tick();
        expect_out("stray_svc", KSvc, 3'd0, 32'h0);
        expect_out("stray_req", KReq, 3'd0, 32'h0);
        expect_out("stray_vec", KDout, RegVec, 32'h0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
